// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - registered N:1 channel multiplexer with direct-select and round-robin grant
//
// Optional feature macro: ARB_MUX_XFER_CNT_EN
//   defined   : xfer_cnt counts output handshakes (16-bit, wraps, cleared by reset)
//   undefined : xfer_cnt is tied to zero and no counter flops exist
//
// Parameters:
//   WIDTH  - data bits per channel
//   NUM_IN - number of input channels (2 .. 2**SEL_W)
//   SEL_W  - width of sel / out_sel
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   mode      in   0 = direct select via sel, 1 = round-robin over in_valid
//   sel       in   channel index used in direct mode
//   in_data   in   packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  in   per-channel valid
//   in_ready  out  per-channel ready, one-hot or zero
//   out_data  out  registered selected word
//   out_sel   out  channel index that produced out_data
//   out_valid out  out_data holds an unconsumed word
//   out_ready in   consumer accepts the word while out_valid is high
//   xfer_cnt  out  output handshake counter (see macro above)

module arb_mux_n #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_cnt
);

  // Reset value of the round-robin pointer: pointing at the last channel
  // makes channel 0 the first candidate after reset.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

  // Output stage and arbitration state
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic [SEL_W-1:0] out_sel_q,    out_sel_d;
  logic             out_valid_q,  out_valid_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  // Combinational grant path
  logic             load;
  logic             dir_vld;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             in_xfer;
  logic             out_xfer;

  // The output register can take a new word when it is empty or its
  // current word leaves on this same edge.
  assign load = ~out_valid_q | out_ready;

  // Direct mode: a sel value beyond the last channel matches no loop index,
  // so it can never grant.
  always_comb begin
    dir_vld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        dir_vld = 1'b1;
      end
    end
  end

  // Round-robin: walk offsets from farthest to nearest so that the
  // nearest valid channel after last_grant is the one that sticks.
  always_comb begin
    int idx;
    idx    = 0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      for (int j = 0; j < NUM_IN; j++) begin
        if (idx == j && in_valid[j]) begin
          rr_vld = 1'b1;
          rr_idx = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else begin
      grant_vld = dir_vld;
      grant_idx = sel;
    end
  end

  // A grant only exists for a valid channel, so a granted and loadable
  // channel is a completed input transfer.
  assign in_xfer  = grant_vld & load;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = in_xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state of the output stage and the round-robin pointer
  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (in_xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      // Direct-mode traffic leaves the rotation where it was.
      if (mode) begin
        last_grant_d = grant_idx;
      end
    end else if (out_xfer) begin
      // Word consumed with nothing to replace it: data and index hold.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= LAST_CH;
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef ARB_MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_xfer) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - directed self-checking bench for arb_mux_n

module tb_arb_mux_n;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    reset;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             xfer_cnt;

  int n_checks;
  int n_fail;

  arb_mux_n #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    logic [NUM_IN-1:0] onehot;
    int                n_hs;
    logic [15:0]       exp_cnt;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = '0;
    for (int i = 0; i < NUM_IN; i++) set_ch(i, WIDTH'(i));

    // Reset state
    tick();
    tick();
    check_out("reset", 1'b0, 16'h0000, 3'd0);
    check("reset.xfer_cnt", 32'(xfer_cnt), 32'h0);
    check("reset.in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;

    // Single direct-select transfer from channel 3
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b1;
    #1;
    check("dir3.in_ready", 32'(in_ready), 32'h08);
    tick();
    check_out("dir3.out", 1'b1, 16'h0003, 3'd3);
    in_valid = 8'h00;
    #1;
    check("dir3.idle_ready", 32'(in_ready), 32'h00);
    tick();
    check("dir3.drained", 32'(out_valid), 32'h0);

    // Direct sweep over every channel, all valid
    in_valid = 8'hFF;
    for (int s = 0; s < NUM_IN; s++) begin
      sel = SEL_W'(s);
      onehot = 8'h01 << s;
      #1;
      check("sweep.in_ready", 32'(in_ready), 32'(onehot));
      tick();
      check_out("sweep.out", 1'b1, WIDTH'(s), SEL_W'(s));
    end

    // Selected channel not valid: no grant, pending word drains
    sel = 3'd5; in_valid = 8'hDF;
    #1;
    check("sel5_invalid.in_ready", 32'(in_ready), 32'h00);
    tick();
    check_out("sel5_invalid.out", 1'b0, 16'h0007, 3'd7);

    // Round-robin, all valid: 0..7 then wrap to 0
    mode = 1'b1; in_valid = 8'hFF;
    for (int k = 0; k <= NUM_IN; k++) begin
      onehot = 8'h01 << (k % NUM_IN);
      #1;
      check("rr_all.in_ready", 32'(in_ready), 32'(onehot));
      tick();
      check_out("rr_all.out", 1'b1, WIDTH'(k % NUM_IN), SEL_W'(k % NUM_IN));
    end

    // Round-robin between channels 2 and 5 (pointer now at 0)
    in_valid = 8'b0010_0100;
    for (int k = 0; k < 4; k++) begin
      onehot = (k % 2 == 0) ? 8'h04 : 8'h20;
      #1;
      check("rr_2_5.in_ready", 32'(in_ready), 32'(onehot));
      tick();
      check("rr_2_5.out_sel", 32'(out_sel), (k % 2 == 0) ? 32'd2 : 32'd5);
    end
    in_valid = 8'b0000_0100;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rr_2only.in_ready", 32'(in_ready), 32'h04);
      tick();
      check_out("rr_2only.out", 1'b1, 16'h0002, 3'd2);
    end

    // Backpressure: hold 16'h00AA from channel 2 for three stalled cycles
    mode = 1'b0; sel = 3'd2; set_ch(2, 16'h00AA); in_valid = 8'h04; out_ready = 1'b1;
    tick();
    check_out("bp.load", 1'b1, 16'h00AA, 3'd2);
    out_ready = 1'b0; set_ch(1, 16'h0011); in_valid = 8'h06; sel = 3'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp.stall_ready", 32'(in_ready), 32'h00);
      tick();
      check_out("bp.stall_out", 1'b1, 16'h00AA, 3'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'h02);
    tick();
    check_out("bp.release_out", 1'b1, 16'h0011, 3'd1);

    // Reset while a word is held
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    check_out("midreset", 1'b0, 16'h0000, 3'd0);
    check("midreset.xfer_cnt", 32'(xfer_cnt), 32'h0);
    reset = 1'b0;

    // Pointer is back at the last channel: channel 0 wins first
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    check("postreset.rr_first", 32'(in_ready), 32'h01);

    // Streaming run for the handshake counter: first edge only loads,
    // every later edge is a handshake.
`ifdef ARB_MUX_XFER_CNT_EN
    n_hs    = 70000;
    exp_cnt = 16'd4464;
`else
    n_hs    = 100;
    exp_cnt = 16'd0;
`endif
    tick();
    for (int k = 0; k < n_hs; k++) tick();
    check("xfer_cnt.final", 32'(xfer_cnt), 32'(exp_cnt));
    check("stream.out_valid", 32'(out_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
